thor2024_fetch_buffer: RTL
==========================

// Module: thor2024_fetch_buffer
// PURPOSE
// - Double-buffered instruction fetch buffer: two 2-slot pairs, A/B and C/D.
// - Each cache hit at the current PC loads two instructions into the empty pair.
// - Presents the active pair to the enqueue stage and retires slots as they are enqueued.
// - Detects backward branches and produces fetchbuf/fetchbufX_v/backbrX/branchback/backpc.
//   These signals steer the PC register.
// PARAMETERS
// - INSN_W   40  instruction slot width, bits
// - PC_STEP  5   PC increment between slot 0 and slot 1 of a fetch pair
// - CNT_W    32  performance counter width (FETCHBUF_PERF_EN only)
// PORTS
// - clk          in   1       clock, all state on posedge
// - rst_n        in   1       reset, asynchronous, active-low
// - hit          in   1       I-cache hit; ic_insn*/ic_backbr/ic_tgt* valid for pc
// - pc           in   PC      current fetch PC (pc_address_t)
// - ic_insn0/1   in   INSN_W  instruction at pc / pc+PC_STEP
// - ic_backbr    in   2       per-slot backward-branch flag from predecode
// - ic_tgt0/1    in   PC      per-slot branch target
// - branchmiss   in   1       pipeline flush
// - deq_cnt      in   2       instructions taken from active pair this cycle (0..2)
// - fetchbuf     out  1       active pair: 0=A/B, 1=C/D
// - fetchbufA_v..D_v  out 1   slot valid
// - fbA_insn..fbD_insn out INSN_W  slot instruction
// - fbA_pc..fbD_pc     out PC      slot PC
// - backbrA..D   out  1       slot valid && backward branch
// - branchback   out  1       active pair holds a valid backward branch
// - backpc       out  PC      target of oldest valid backward branch in active pair
// - stall_cnt    out  CNT_W   hit cycles with no empty pair
// - empty_cnt    out  CNT_W   cycles with active pair empty
// BEHAVIOUR
// - Reset (rst_n=0, async): all valids 0, fetchbuf 0, insn/pc/flag regs 0, counters 0.
// - Priority per cycle: branchmiss > branchback > dequeue/load.
// - branchmiss:
//   - Clear all four valids and set fetchbuf<=0.
//   - Ignore hit and deq_cnt that cycle.
// - Load:
//   - Condition: hit && !branchmiss && !branchback.
//   - Target is the first empty pair: A/B if both A,B invalid, else C/D if both invalid.
//   - Fill: slot0<=ic_insn0,pc; slot1<=ic_insn1,pc+PC_STEP; flags<=ic_backbr; both valids<=1.
//   - Latency: visible the cycle after the hit.
//   - Both pairs non-empty: load dropped; PC register holds pc.
// - Dequeue (no branchmiss): deq_cnt acts on active pair, oldest slot first.
//   - deq_cnt=1: clear oldest valid slot.
//   - deq_cnt=2: clear both slots.
//   - deq_cnt greater than valid count: clamp to valid count; assertion fires.
// - Toggle:
//   - If the active pair is empty after dequeue, fetchbuf flips on the same edge.
//   - A pair loaded on that edge becomes active immediately.
// - branchback, backbrX, backpc: combinational from registered slot state only.
//   - branchback = backbr of valid slot0 || backbr of valid slot1 in active pair.
//   - backpc = slot0 target if slot0 qualifies, else slot1 target.
// - Stomp, while branchback:
//   - Slot0 is backbr: clear slot1 of the active pair.
//   - Clear the inactive pair (wrong path).
//   - Inhibit load.
//   - Dequeue proceeds on the surviving slots.
// - Stomp is idempotent: re-asserted branchback with already-stomped state changes nothing.
// - Reset mid-operation: immediate return to reset values, no residual valids.
// CONFIGURATION
// - FETCHBUF_PERF_EN defined:
//   - stall_cnt increments on hit && no empty pair && !branchmiss.
//   - empty_cnt increments when the active pair has no valid slot.
//   - Both counters saturate at all-ones; cleared only by reset.
// - FETCHBUF_PERF_EN undefined: counter logic removed; stall_cnt/empty_cnt tied to 0.
// TESTING
// - Empty buffer, hit, pc=0x100: next cycle A_v=B_v=1, fbB_pc=0x105, fetchbuf=0.
// - A/B full, second hit pc=0x10A: C/D filled; third hit dropped, C/D unchanged.
//   - With FETCHBUF_PERF_EN: stall_cnt=1 after the dropped hit.
// - A/B full, deq_cnt=2, C/D full: A/B cleared, fetchbuf=1 next cycle.
//   - deq_cnt=1 on C/D: only C cleared.
// - Load with ic_backbr=2'b01, ic_tgt0=0x080: branchback=1, backpc=0x080, backbrA=1.
//   - Next cycle: B_v=0, C/D invalid, no load while branchback held.
// - Both pairs full, branchmiss with hit and deq_cnt=2 same cycle: all valids 0, fetchbuf=0.
// - Pulse rst_n low asynchronously mid-load: outputs 0 before the next clk edge.

Source files
------------

// File: rtl/thor2024_fetch_buffer.sv
// thor2024_fetch_buffer: double-buffered instruction fetch buffer (pairs A/B and C/D).
// Each I-cache hit loads two instructions into the first empty pair. The active
// pair is presented to the enqueue stage, and backward branches in the active pair
// are flagged so the PC register can be steered.
// Optional feature macro: FETCHBUF_PERF_EN enables the stall/empty performance counters.
// Without it, stall_cnt and empty_cnt are tied to zero.

module thor2024_fetch_buffer #(
  parameter int INSN_W  = 40,
  parameter int PC_STEP = 5,
  parameter int CNT_W   = 32,
  parameter int PC_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic [PC_W-1:0]   pc,
  input  logic [INSN_W-1:0] ic_insn0,
  input  logic [INSN_W-1:0] ic_insn1,
  input  logic [1:0]        ic_backbr,
  input  logic [PC_W-1:0]   ic_tgt0,
  input  logic [PC_W-1:0]   ic_tgt1,
  input  logic              branchmiss,
  input  logic [1:0]        deq_cnt,
  output logic              fetchbuf,
  output logic              fetchbufA_v,
  output logic              fetchbufB_v,
  output logic              fetchbufC_v,
  output logic              fetchbufD_v,
  output logic [INSN_W-1:0] fbA_insn,
  output logic [INSN_W-1:0] fbB_insn,
  output logic [INSN_W-1:0] fbC_insn,
  output logic [INSN_W-1:0] fbD_insn,
  output logic [PC_W-1:0]   fbA_pc,
  output logic [PC_W-1:0]   fbB_pc,
  output logic [PC_W-1:0]   fbC_pc,
  output logic [PC_W-1:0]   fbD_pc,
  output logic              backbrA,
  output logic              backbrB,
  output logic              backbrC,
  output logic              backbrD,
  output logic              branchback,
  output logic [PC_W-1:0]   backpc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  empty_cnt
);

  // Slot index 0..3 = A..D; pair p owns slots {p,0} and {p,1}.
  logic [3:0]        v_q, v_d;
  logic [3:0]        bb_q, bb_d;
  logic              fb_q, fb_d;
  logic [INSN_W-1:0] insn_q [4];
  logic [INSN_W-1:0] insn_d [4];
  logic [PC_W-1:0]   pc_q [4];
  logic [PC_W-1:0]   pc_d [4];
  logic [PC_W-1:0]   tgt_q [4];
  logic [PC_W-1:0]   tgt_d [4];

  logic [1:0] s0, s1, o0, o1;
  logic [3:0] bbv;
  logic [1:0] pair_empty;
  logic       surv0, surv1;
  logic [1:0] surv_cnt;
  logic [1:0] deq_eff;
  logic       lp;

  assign s0 = {fb_q, 1'b0};
  assign s1 = {fb_q, 1'b1};
  assign o0 = {~fb_q, 1'b0};
  assign o1 = {~fb_q, 1'b1};

  assign bbv        = v_q & bb_q;
  assign branchback = bbv[s0] | bbv[s1];
  assign backpc     = bbv[s0] ? tgt_q[s0] : tgt_q[s1];
  assign pair_empty = {~|v_q[3:2], ~|v_q[1:0]};

  // Active-pair slots that survive a stomp; dequeue acts on these, oldest first.
  assign surv0    = v_q[s0];
  assign surv1    = v_q[s1] & ~(branchback & bbv[s0]);
  assign surv_cnt = {1'b0, surv0} + {1'b0, surv1};
  assign deq_eff  = (deq_cnt > surv_cnt) ? surv_cnt : deq_cnt;
  // First empty pair, judged on the registered state before this edge's dequeue.
  assign lp       = ~pair_empty[0];

  // Next-state: flush, stomp, dequeue, load, then flip to the other pair if the active one drained.
  always_comb begin
    v_d  = v_q;
    bb_d = bb_q;
    fb_d = fb_q;
    for (int i = 0; i < 4; i++) begin
      insn_d[i] = insn_q[i];
      pc_d[i]   = pc_q[i];
      tgt_d[i]  = tgt_q[i];
    end
    if (branchmiss) begin
      v_d  = 4'b0000;
      fb_d = 1'b0;
    end else begin
      if (branchback) begin
        v_d[o0] = 1'b0;
        v_d[o1] = 1'b0;
        v_d[s1] = surv1;
      end else begin
        v_d[s1] = v_q[s1];
      end
      case (deq_eff)
        2'd2: begin
          v_d[s0] = 1'b0;
          v_d[s1] = 1'b0;
        end
        2'd1: begin
          if (v_d[s0]) begin
            v_d[s0] = 1'b0;
          end else begin
            v_d[s1] = 1'b0;
          end
        end
        default: begin
          v_d[s0] = v_d[s0];
        end
      endcase
      if (hit && !branchback && (pair_empty != 2'b00)) begin
        insn_d[{lp, 1'b0}] = ic_insn0;
        insn_d[{lp, 1'b1}] = ic_insn1;
        pc_d[{lp, 1'b0}]   = pc;
        pc_d[{lp, 1'b1}]   = pc + PC_W'(PC_STEP);
        tgt_d[{lp, 1'b0}]  = ic_tgt0;
        tgt_d[{lp, 1'b1}]  = ic_tgt1;
        bb_d[{lp, 1'b0}]   = ic_backbr[0];
        bb_d[{lp, 1'b1}]   = ic_backbr[1];
        v_d[{lp, 1'b0}]    = 1'b1;
        v_d[{lp, 1'b1}]    = 1'b1;
      end else begin
        bb_d = bb_q;
      end
      if (!v_d[s0] && !v_d[s1]) begin
        fb_d = ~fb_q;
      end else begin
        fb_d = fb_q;
      end
    end
  end

  // Slot state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= 4'b0000;
      bb_q <= 4'b0000;
      fb_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        insn_q[i] <= '0;
        pc_q[i]   <= '0;
        tgt_q[i]  <= '0;
      end
    end else begin
      v_q  <= v_d;
      bb_q <= bb_d;
      fb_q <= fb_d;
      for (int i = 0; i < 4; i++) begin
        insn_q[i] <= insn_d[i];
        pc_q[i]   <= pc_d[i];
        tgt_q[i]  <= tgt_d[i];
      end
    end
  end

  assign fetchbuf    = fb_q;
  assign fetchbufA_v = v_q[0];
  assign fetchbufB_v = v_q[1];
  assign fetchbufC_v = v_q[2];
  assign fetchbufD_v = v_q[3];
  assign fbA_insn    = insn_q[0];
  assign fbB_insn    = insn_q[1];
  assign fbC_insn    = insn_q[2];
  assign fbD_insn    = insn_q[3];
  assign fbA_pc      = pc_q[0];
  assign fbB_pc      = pc_q[1];
  assign fbC_pc      = pc_q[2];
  assign fbD_pc      = pc_q[3];
  assign backbrA     = bbv[0];
  assign backbrB     = bbv[1];
  assign backbrC     = bbv[2];
  assign backbrD     = bbv[3];

`ifdef FETCHBUF_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, empty_q, empty_d;

  // Saturating counters: hits dropped for lack of an empty pair, and cycles with the active pair empty.
  always_comb begin
    stall_d = stall_q;
    empty_d = empty_q;
    if (hit && (pair_empty == 2'b00) && !branchmiss && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (!v_q[s0] && !v_q[s1] && (empty_q != {CNT_W{1'b1}})) begin
      empty_d = empty_q + CNT_W'(1);
    end else begin
      empty_d = empty_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      stall_q <= stall_d;
      empty_q <= empty_d;
    end
  end

  assign stall_cnt = stall_q;
  assign empty_cnt = empty_q;
`else
  assign stall_cnt = '0;
  assign empty_cnt = '0;
`endif

  thor2024_fetch_buffer_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .branchmiss (branchmiss),
    .deq_cnt    (deq_cnt),
    .surv_cnt   (surv_cnt)
  );

endmodule

// Property checker: the enqueue stage must never take more than the active pair holds.
module thor2024_fetch_buffer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       branchmiss,
  input logic [1:0] deq_cnt,
  input logic [1:0] surv_cnt
);

  a_deq_not_over_valid: assert property (@(posedge clk) disable iff (!rst_n)
    branchmiss || (deq_cnt <= surv_cnt));

endmodule
